// File: rtl/sm4_rkey_buf.sv
// SM4 round-key store: captures the 32 serially expanded round keys and serves them
// to the round core with 1-cycle random-access reads, forward or reversed.
module sm4_rkey_buf #(
   parameter int RKEY_W = 32,
   parameter int NUM_RK = 32,
   parameter int IDX_W  = 5
) (
   input  logic              clk_sys,
   input  logic              sys_rst_n,
   input  logic              key_load_start,
   input  logic [RKEY_W-1:0] key2core_rkey,
   input  logic              key2core_rkey_vld,
   input  logic              core_rd_en,
   input  logic [IDX_W-1:0]  core_rd_round,
   input  logic              core_decrypt,
   output logic [RKEY_W-1:0] rkey_out,
   output logic              rkey_out_vld,
   output logic              rkey_ready,
   output logic              rkey_done,
   output logic              rd_err,
   output logic              wr_ovf
);

   // Handshake: key2core_rkey is taken on every edge where key2core_rkey_vld=1 (no
   // backpressure); a core_rd_en read is answered one cycle later by rkey_out_vld or rd_err.
   typedef enum logic {FILL = 1'b0, READY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [RKEY_W-1:0] mem_q [NUM_RK];
   logic [RKEY_W-1:0] mem_d [NUM_RK];
   logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [RKEY_W-1:0] rkey_out_q, rkey_out_d;
   logic              rkey_out_vld_q, rkey_out_vld_d;
   logic              rkey_done_q, rkey_done_d;
   logic              rd_err_q, rd_err_d;
   logic              wr_ovf_q, wr_ovf_d;
   logic [IDX_W-1:0]  rd_addr;

   // Decrypt walks the set backwards: 31 - i is just the bitwise inverse of a 5-bit index.
   always_comb begin
      rd_addr = core_decrypt ? ~core_rd_round : core_rd_round;
   end

   always_comb begin
      state_d        = state_q;
      mem_d          = mem_q;
      wr_cnt_d       = wr_cnt_q;
      wr_ovf_d       = wr_ovf_q;
      rkey_out_d     = rkey_out_q;
      rkey_out_vld_d = 1'b0;
      rkey_done_d    = 1'b0;
      rd_err_d       = 1'b0;

      if (key_load_start) begin
         state_d  = FILL;
         wr_cnt_d = '0;
         wr_ovf_d = 1'b0;
      end else if (key2core_rkey_vld) begin
         if (state_q == FILL) begin
            mem_d[wr_cnt_q] = key2core_rkey;
            wr_cnt_d        = wr_cnt_q + 1'b1;
            if (wr_cnt_q == IDX_W'(NUM_RK - 1)) begin
               state_d     = READY;
               rkey_done_d = 1'b1;
            end
         end else begin
            wr_ovf_d = 1'b1;
         end
      end

      // Reads use the pre-edge state, so a read beside key_load_start hits the old set.
      if (core_rd_en) begin
         if (state_q == READY) begin
            rkey_out_d     = mem_q[rd_addr];
            rkey_out_vld_d = 1'b1;
         end else begin
            rd_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= FILL;
         for (int i = 0; i < NUM_RK; i++) begin
            mem_q[i] <= '0;
         end
         wr_cnt_q       <= '0;
         rkey_out_q     <= '0;
         rkey_out_vld_q <= 1'b0;
         rkey_done_q    <= 1'b0;
         rd_err_q       <= 1'b0;
         wr_ovf_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_q          <= mem_d;
         wr_cnt_q       <= wr_cnt_d;
         rkey_out_q     <= rkey_out_d;
         rkey_out_vld_q <= rkey_out_vld_d;
         rkey_done_q    <= rkey_done_d;
         rd_err_q       <= rd_err_d;
         wr_ovf_q       <= wr_ovf_d;
      end
   end

   assign rkey_ready   = (state_q == READY);
   assign rkey_out     = rkey_out_q;
   assign rkey_out_vld = rkey_out_vld_q;
   assign rkey_done    = rkey_done_q;
   assign rd_err       = rd_err_q;
   assign wr_ovf       = wr_ovf_q;

endmodule

// File: doc/sm4_rkey_buf.md
Name: sm4_rkey_buf

Overview:
- Round-key store directly downstream of the SM4 key-expansion stage.
- Captures the 32 serially produced 32-bit round keys and holds them as one key set.
- Serves the SM4 round core with random-access reads, 1-cycle latency.
- Order is forward for encrypt and reversed for decrypt, so one key expansion serves both directions.

Parameters:
- RKEY_W, 32, width of one round key.
- NUM_RK, 32, round keys per key set; fixed by the SM4 algorithm and not meant to be overridden.
- IDX_W, 5, width of the write counter and read index (log2 of NUM_RK).

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- key_load_start  in  1  new key expansion starting (sm4_start & sm4_key_in_vld); invalidates the stored set.
- key2core_rkey  in  RKEY_W  round key from the expansion stage.
- key2core_rkey_vld  in  1  key2core_rkey valid this cycle; rk0..rk31 arrive in order, not necessarily back-to-back.
- core_rd_en  in  1  round core requests a round key.
- core_rd_round  in  IDX_W  round number 0..31 as seen by the core.
- core_decrypt  in  1  1 = map round i to rk[31-i]; 0 = rk[i].
- rkey_out  out  RKEY_W  registered round key.
- rkey_out_vld  out  1  rkey_out valid, 1-cycle pulse per accepted read.
- rkey_ready  out  1  complete 32-key set stored.
- rkey_done  out  1  1-cycle pulse in the cycle after rk31 is written.
- rd_err  out  1  1-cycle pulse: read requested while rkey_ready = 0.
- wr_ovf  out  1  sticky: key word received while the set was already complete.

Behaviour:
- Reset (async assert, sync release): wr_cnt = 0, all 32 mem words = 0, all outputs = 0.
- Storage: 32 x RKEY_W register array `mem`, write counter `wr_cnt` [IDX_W-1:0].
- States, held in rkey_ready: FILL (0) and READY (1).
- FILL, key2core_rkey_vld = 1:
  - mem[wr_cnt] <= key2core_rkey; wr_cnt <= wr_cnt + 1.
  - When wr_cnt == 31: wr_cnt wraps to 0, rkey_ready <= 1, rkey_done pulses the next cycle.
- READY, key2core_rkey_vld = 1: no write, wr_cnt unchanged, wr_ovf <= 1 (sticky).
- key_load_start = 1, any state, next edge:
  - rkey_ready <= 0, wr_cnt <= 0, wr_ovf <= 0.
  - mem contents are not cleared.
  - key_load_start has priority over a simultaneous key2core_rkey_vld; that word is dropped.
  - The expansion stage emits rk0 no earlier than the cycle after key_load_start.
- Read when core_rd_en = 1 and rkey_ready = 1:
  - Next cycle rkey_out = mem[core_decrypt ? 31 - core_rd_round : core_rd_round], rkey_out_vld = 1.
  - Address is computed as 5-bit (~core_rd_round) for decrypt.
- Read when core_rd_en = 1 and rkey_ready = 0: next cycle rd_err = 1, rkey_out_vld = 0, rkey_out holds its previous value.
- rkey_out holds its last value when no read occurs; rkey_out_vld = 0 otherwise.
- Reads are allowed every cycle, any index order.
- A read in the same cycle as key_load_start uses the pre-edge rkey_ready (1), so it is served from the old set.
- A read in the same cycle as the rk31 write sees rkey_ready = 0 and produces rd_err.
- Reset mid-fill: partial set discarded (wr_cnt = 0, rkey_ready = 0); the next fill must start from rk0.

Test Plan:
- Reset, then core_rd_en with round 0 → rd_err pulses 1 cycle; rkey_out = 0; rkey_out_vld = 0.
- key_load_start, then 32 words from expansion of key 0123456789ABCDEFFEDCBA9876543210, with random vld gaps:
  - rkey_done pulses once, one cycle after rk31; rkey_ready = 1.
  - Encrypt read round 0 → rkey_out = F12186F9 one cycle later.
  - Encrypt read round 31 → rkey_out = 9124A012.
- Same set, core_decrypt = 1:
  - Read round 0 → 9124A012.
  - Read round 31 → F12186F9.
  - Back-to-back reads of rounds 0..31 → 32 consecutive rkey_out_vld cycles, reversed order.
- After READY, one extra key2core_rkey_vld with data DEADBEEF → wr_ovf = 1; encrypt read round 0 still F12186F9; next key_load_start clears wr_ovf.
- key_load_start after 10 words, then a full 32-word set with all-zero master key:
  - rkey_ready = 0 until the new rk31 is written.
  - Final contents match the reference model for the new key only.
- Assert sys_rst_n low for 1 cycle mid-fill (after 20 words) → rkey_ready = 0, wr_cnt = 0; then a full reload stores correctly.
